// File: rtl/adc_scan_sequencer.sv
// Periodic ADC scan sequencer: converts every enabled channel, keeps results in a register file, streams them out.
// Optional ADC_SCAN_AVG_EN: each channel is converted four times and the average is stored.

module adc_scan_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_en,
    input  logic [7:0]  ch_mask,
    input  logic [15:0] period,
    output logic [2:0]  adc_chan,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [11:0] adc_result,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data,
    output logic        sample_valid,
    output logic [2:0]  sample_chan,
    output logic [11:0] sample_data,
    output logic        scan_done,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {IDLE, START, CONVERT, STORE} state_t;

    state_t      state;
    logic [15:0] period_cnt;
    logic [7:0]  mask_snap;
    logic [2:0]  ptr;
    logic [7:0]  conv_cnt;
    logic [11:0] regs [8];
`ifdef ADC_SCAN_AVG_EN
    logic [1:0]  pass;
    logic [13:0] acc;
    logic [13:0] sum_next;
`endif

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [3:0] next_set(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (4'(i) >= lo)) r = {1'b1, 3'(i)};
        return r;
    endfunction

    logic [3:0] first_ch;
    logic [3:0] next_ch;
    logic       scan_go;
    logic       timeout;
    logic       chan_end;

    // NOTE: every signal here is assigned on every pass through the block, so no latch can be inferred.
    always_comb begin
        first_ch = next_set(ch_mask, 4'd0);
        next_ch  = next_set(mask_snap, {1'b0, ptr} + 4'd1);
        scan_go  = (state == IDLE) && scan_en && first_ch[3] && (period_cnt == 16'd0);
        timeout  = (state == CONVERT) && !adc_done && (conv_cnt == 8'd254);
        chan_end = (state == STORE) || timeout;
    end

`ifdef ADC_SCAN_AVG_EN
    assign sum_next = acc + {2'b00, adc_result};
`endif

    assign rd_data = regs[rd_chan];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            period_cnt   <= '0;
            mask_snap    <= '0;
            ptr          <= '0;
            conv_cnt     <= '0;
            adc_chan     <= '0;
            adc_start    <= 1'b0;
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            timeout_err  <= 1'b0;
            // NOTE: the register file must read back zero after reset, so it is built from resettable flops, not RAM.
            for (int i = 0; i < 8; i++) regs[i] <= '0;
`ifdef ADC_SCAN_AVG_EN
            pass         <= '0;
            acc          <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments, last one wins: pulses default low and a timeout overrides err_clr.
            adc_start    <= 1'b0;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;

            // Loaded one short: the reload cycle itself is the first cycle of the period.
            if (scan_go)
                period_cnt <= (period == 16'd0) ? 16'd0 : period - 16'd1;
            else if (period_cnt != 16'd0)
                period_cnt <= period_cnt - 16'd1;

            case (state)
                IDLE: begin
                    if (scan_go) begin
                        mask_snap <= ch_mask;
                        ptr       <= first_ch[2:0];
                        adc_chan  <= first_ch[2:0];
                        adc_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    conv_cnt <= '0;
                    state    <= CONVERT;
                end
                CONVERT: begin
                    if (adc_done) begin
`ifdef ADC_SCAN_AVG_EN
                        if (pass == 2'd3) begin
                            sample_valid <= 1'b1;
                            sample_chan  <= ptr;
                            sample_data  <= sum_next[13:2];
                            state        <= STORE;
                        end else begin
                            acc       <= sum_next;
                            pass      <= pass + 2'd1;
                            adc_start <= 1'b1;
                            state     <= START;
                        end
`else
                        sample_valid <= 1'b1;
                        sample_chan  <= ptr;
                        sample_data  <= adc_result;
                        state        <= STORE;
`endif
                    end else if (timeout) begin
                        timeout_err <= 1'b1;
                    end else begin
                        conv_cnt <= conv_cnt + 8'd1;
                    end
                end
                STORE: begin
                    regs[ptr] <= sample_data;
                end
            endcase

            // Channel finished (stored or timed out): advance within the snapshot or end the scan.
            if (chan_end) begin
`ifdef ADC_SCAN_AVG_EN
                pass <= '0;
                acc  <= '0;
`endif
                if (scan_en && next_ch[3]) begin
                    ptr       <= next_ch[2:0];
                    adc_chan  <= next_ch[2:0];
                    adc_start <= 1'b1;
                    state     <= START;
                end else begin
                    scan_done <= scan_en;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: emulated ADC core, event monitor and a transaction-level scan model.
// Follows ADC_SCAN_AVG_EN the same way the design does.
`timescale 1ns/1ps

module tb_adc_scan_sequencer;

`ifdef ADC_SCAN_AVG_EN
    localparam int NPASS = 4;
    localparam int SHIFT = 2;
`else
    localparam int NPASS = 1;
    localparam int SHIFT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scan_en = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic [15:0] period = '0;
    logic [2:0]  adc_chan;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [11:0] adc_result = '0;
    logic [2:0]  rd_chan = '0;
    logic [11:0] rd_data;
    logic        sample_valid;
    logic [2:0]  sample_chan;
    logic [11:0] sample_data;
    logic        scan_done;
    logic        timeout_err;
    logic        err_clr = 1'b0;

    adc_scan_sequencer dut (
        .clk(clk), .reset(reset), .scan_en(scan_en), .ch_mask(ch_mask), .period(period),
        .adc_chan(adc_chan), .adc_start(adc_start), .adc_done(adc_done), .adc_result(adc_result),
        .rd_chan(rd_chan), .rd_data(rd_data),
        .sample_valid(sample_valid), .sample_chan(sample_chan), .sample_data(sample_data),
        .scan_done(scan_done), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [2:0] ch; } start_t;
    typedef struct { logic [2:0] ch; logic [11:0] d; } smp_t;

    start_t      start_q[$];
    smp_t        samp_q[$];
    smp_t        conv_q[$];
    logic [11:0] exp_reg [8];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          terr_rise = -1;
    logic        terr_prev = 1'b0;
    int          prev_s = 0;
    int          prev_d = 0;

    // ADC emulation knobs
    logic        resp_en = 1'b0;
    int          lat = 5;
    int          mode = 0;
    int          cd = 0;
    int          seq_idx = 0;
    logic [2:0]  r_ch = '0;
    logic [11:0] r_val = '0;
    logic [11:0] avg_seq [4] = '{12'd100, 12'd101, 12'd102, 12'd105};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: logs DUT events at the falling edge.
    initial forever begin
        @(negedge clk);
        if (adc_start) start_q.push_back(start_t'{cyc, adc_chan});
        if (sample_valid) samp_q.push_back(smp_t'{sample_chan, sample_data});
        if (scan_done) done_cnt++;
        if (timeout_err && !terr_prev) terr_rise = cyc;
        terr_prev = timeout_err;
    end

    // ADC core: answers each adc_start with one adc_done pulse lat cycles later.
    initial forever begin
        @(negedge clk);
        if (resp_en) begin
            adc_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    adc_result = r_val;
                    adc_done   = 1'b1;
                    conv_q.push_back(smp_t'{r_ch, r_val});
                end
            end else if (adc_start) begin
                r_ch = adc_chan;
                cd   = lat;
                case (mode)
                    1:       r_val = 12'h100 + {9'd0, adc_chan};
                    2:       begin r_val = avg_seq[seq_idx % 4]; seq_idx++; end
                    default: r_val = 12'($urandom);
                endcase
            end
        end
    end

    task automatic flush();
        start_q.delete();
        samp_q.delete();
        conv_q.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(output int d, input logic stop);
        int k;
        d = -1;
        k = 0;
        while (d < 0 && k < 20000) begin
            @(negedge clk);
            k++;
            if (scan_done) begin
                d = cyc;
                if (stop) scan_en = 1'b0;
            end
        end
        check("scan_done_seen", d >= 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_starts(input int n);
        int k;
        k = 0;
        while (start_q.size() < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("start_seen", start_q.size() >= n, 1);
    endtask

    // A scan over mask m issues NPASS starts per set bit, lowest channel first.
    task automatic check_starts(input logic [7:0] m);
        start_t s;
        check("start_count", start_q.size() >= NPASS * $countones(m), 1);
        for (int c = 0; c < 8; c++)
            if (m[c])
                for (int p = 0; p < NPASS; p++)
                    if (start_q.size() > 0) begin
                        s = start_q.pop_front();
                        check("start_chan", s.ch, c);
                    end
    endtask

    // One sample per channel, value = mean of its NPASS conversions; the register file follows.
    task automatic check_samples(input logic [7:0] m);
        smp_t cv;
        smp_t sv;
        int   sum;
        check("sample_count", samp_q.size(), $countones(m));
        for (int c = 0; c < 8; c++)
            if (m[c]) begin
                sum = 0;
                for (int p = 0; p < NPASS; p++)
                    if (conv_q.size() > 0) begin
                        cv = conv_q.pop_front();
                        check("conv_chan", cv.ch, c);
                        sum += int'(cv.d);
                    end
                exp_reg[c] = 12'(sum >> SHIFT);
                if (samp_q.size() > 0) begin
                    sv = samp_q.pop_front();
                    check("sample_chan", sv.ch, c);
                    check("sample_data", sv.d, exp_reg[c]);
                end
            end
    endtask

    // Next scan starts at prev_start+period or on the first IDLE cycle after the previous scan, whichever is later.
    task automatic check_scan(input logic [7:0] m, input logic stop, input logic chk_int);
        int d;
        int s0;
        int want;
        wait_done(d, stop);
        s0 = (start_q.size() > 0) ? start_q[0].cyc : -1;
        if (chk_int) begin
            want = prev_s + int'(period);
            if (prev_d + 1 > want) want = prev_d + 1;
            check("scan_interval", s0, want);
        end
        prev_s = s0;
        prev_d = d;
        check_starts(m);
        check_samples(m);
    endtask

    task automatic check_regs();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rd_chan = 3'(c);
            #1;
            check("regfile", rd_data, exp_reg[c]);
        end
    endtask

    task automatic end_test(input int exp_done);
        repeat (5) @(negedge clk);
        check("stray_starts", start_q.size(), 0);
        check("stray_samples", samp_q.size(), 0);
        check("scan_done_count", done_cnt, exp_done);
        check_regs();
        flush();
    endtask

    int pers [5] = '{0, 1, 7, 60, 300};
    int d;
    int s0;

    initial begin
        for (int c = 0; c < 8; c++) exp_reg[c] = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_adc_start", adc_start, 0);
        check("rst_adc_chan", adc_chan, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_sample_data", sample_data, 0);
        check("rst_scan_done", scan_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        check_regs();

        // Reference scan: channels 0,2,5,7, 20-cycle conversions, results 0x100+chan.
        flush();
        ch_mask = 8'hA5; period = 16'd100; lat = 20; mode = 1; resp_en = 1'b1;
        scan_en = 1'b1;
        check_scan(8'hA5, 1'b0, 1'b0);
        check_scan(8'hA5, 1'b1, 1'b1);
        rd_chan = 3'd5;
        #1 check("req_reg5", rd_data, 12'h105);
        end_test(2);

        // Randomized masks, latencies and periods.
        for (int t = 0; t < 6; t++) begin
            flush();
            ch_mask = 8'($urandom_range(1, 255));
            period  = 16'(pers[t % 5]);
            lat     = int'($urandom_range(1, 25));
            mode    = 0;
            scan_en = 1'b1;
            check_scan(ch_mask, 1'b0, 1'b0);
            check_scan(ch_mask, 1'b1, 1'b1);
            end_test(2);
        end

        // Mask change during channel 0 conversion only affects the following scan.
        flush();
        ch_mask = 8'h03; period = 16'd0; lat = 20; mode = 0;
        scan_en = 1'b1;
        wait_starts(1);
        @(negedge clk);
        ch_mask = 8'h80;
        check_scan(8'h03, 1'b0, 1'b0);
        check_scan(8'h80, 1'b1, 1'b1);
        end_test(2);

        // scan_en dropped during channel 1: channel 1 completes, no scan_done, nothing further.
        flush();
        ch_mask = 8'h0F; period = 16'd0; lat = 8; mode = 0;
        scan_en = 1'b1;
        wait_starts(NPASS + 1);
        scan_en = 1'b0;
        repeat (200) @(negedge clk);
        check_starts(8'h03);
        check_samples(8'h03);
        end_test(0);

        // Averaging sequence on channel 3.
        flush();
        ch_mask = 8'h08; period = 16'd0; lat = 3; mode = 2; seq_idx = 0;
        scan_en = 1'b1;
        check_scan(8'h08, 1'b1, 1'b0);
        rd_chan = 3'd3;
`ifdef ADC_SCAN_AVG_EN
        #1 check("avg_reg3", rd_data, 12'd102);
`else
        #1 check("single_reg3", rd_data, 12'd100);
`endif
        end_test(1);

        // Timeout: no adc_done ever.
        flush();
        resp_en = 1'b0; adc_done = 1'b0;
        ch_mask = 8'h01; period = 16'd0; terr_rise = -1;
        scan_en = 1'b1;
        wait_done(d, 1'b1);
        s0 = (start_q.size() > 0) ? start_q[0].cyc : -1;
        check("timeout_starts", start_q.size(), 1);
        check("timeout_flag_delay", terr_rise - s0, 256);
        check("timeout_done_delay", d - s0, 256);
        check("timeout_no_sample", samp_q.size(), 0);
        check("timeout_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", timeout_err, 0);
        start_q.delete();

        // err_clr held through a new timeout: the timeout wins that cycle.
        terr_rise = -1;
        err_clr = 1'b1;
        scan_en = 1'b1;
        wait_done(d, 1'b1);
        s0 = (start_q.size() > 0) ? start_q[0].cyc : -1;
        check("errclr_vs_timeout", terr_rise - s0, 256);
        check("errclr_after", timeout_err, 0);
        err_clr = 1'b0;
        start_q.delete();
        end_test(2);

        // Reset in CONVERT, then a late adc_done.
        flush();
        ch_mask = 8'h40; period = 16'd0;
        scan_en = 1'b1;
        wait_starts(1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        scan_en = 1'b0;
        @(negedge clk);
        flush();
        check("rrst_adc_chan", adc_chan, 0);
        check("rrst_adc_start", adc_start, 0);
        check("rrst_sample_chan", sample_chan, 0);
        check("rrst_sample_data", sample_data, 0);
        check("rrst_timeout_err", timeout_err, 0);
        for (int c = 0; c < 8; c++) exp_reg[c] = '0;
        check_regs();
        reset = 1'b0;
        @(negedge clk);
        adc_result = 12'hABC;
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
        repeat (10) @(negedge clk);
        check("late_done_sample_data", sample_data, 0);
        check("late_done_adc_chan", adc_chan, 0);
        end_test(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: scan_en  input  1  enables periodic scanning.
REQ-004 SHALL have: ch_mask  input  8  channel enable mask, bit n = ADC channel n.
REQ-005 SHALL have: period  input  16  clk cycles from one scan start to the next.
REQ-006 SHALL have: adc_chan  output  3  channel presented to ADC core.
REQ-007 SHALL have: adc_start  output  1  one-cycle conversion request.
REQ-008 SHALL have: adc_done  input  1  one-cycle pulse, adc_result valid.
REQ-009 SHALL have: adc_result  input  12  conversion result.
REQ-010 SHALL have: rd_chan  input  3  / rd_data  output  12  combinational read of result register file.
REQ-011 SHALL have: sample_valid  output  1  / sample_chan  output  3  / sample_data  output  12  stream of stored results.
REQ-012 SHALL have: scan_done  output  1  one-cycle pulse at completed scan.
REQ-013 SHALL have: timeout_err  output  1  sticky; err_clr  input  1  clears it.

Function
REQ-014 SHALL implement states IDLE, START, CONVERT, STORE.
REQ-015 Period counter (16 bit) SHALL reload with period at each scan start, decrement to 0 and hold at 0.
REQ-016 IDLE -> START when scan_en=1, ch_mask!=0, period counter=0; SHALL snapshot ch_mask; pointer = lowest set bit.
REQ-017 START SHALL drive adc_start=1 for exactly one cycle with adc_chan=pointer, then go to CONVERT.
REQ-018 adc_chan SHALL hold the pointer value from START until leaving STORE.
REQ-019 CONVERT SHALL wait for adc_done; adc_done outside CONVERT SHALL be ignored.
REQ-020 CONVERT SHALL count cycles (8 bit); 255 cycles without adc_done -> timeout_err=1, channel skipped (no write, no sample_valid), go to next channel.
REQ-021 On adc_done: STORE next cycle writes captured adc_result to regfile[pointer], pulses sample_valid with sample_chan/sample_data.
REQ-022 After STORE/timeout: pointer = next higher set bit of snapshot -> START; none -> scan_done pulse, IDLE.
REQ-023 ch_mask/period changes mid-scan SHALL NOT affect the current scan.
REQ-024 scan_en deasserted mid-scan: current channel completes, then IDLE with no scan_done.
REQ-025 Scan longer than period: next scan SHALL start on the first IDLE cycle (no missed-period queueing).
REQ-026 period=0: back-to-back scans, one IDLE cycle between.
REQ-027 err_clr and a new timeout in the same cycle: timeout_err SHALL remain 1.

Reset
REQ-028 Reset SHALL force IDLE, period counter 0, pointer 0, adc_start 0, adc_chan 0, sample_valid 0, sample_chan 0, sample_data 0, scan_done 0, timeout_err 0, all regfile entries 0.
REQ-029 Reset mid-conversion SHALL abandon it; a late adc_done after reset SHALL be ignored.

Configuration
REQ-030 Macro ADC_SCAN_AVG_EN defined: each channel converted 4 times consecutively (4 START/CONVERT passes), 14-bit sum, stored/streamed value = sum>>2, one sample_valid per channel; any timeout discards the channel.
REQ-031 ADC_SCAN_AVG_EN undefined: single conversion per channel, no accumulator logic.

Verification
REQ-032 mask=8'b1010_0101, period=100, done after 20 cycles, results 0x100+chan -> start order 0,2,5,7; regfile 0x100,0x102,0x105,0x107; scan_done once; next scan start 100 cycles after first.
REQ-033 mask=8'h01, adc_done never -> timeout_err=1 after 255 CONVERT cycles, no sample_valid, scan_done pulses; err_clr -> 0.
REQ-034 mask changed 8'h03->8'h80 during channel 0 conversion -> channels 0,1 scanned this scan, channel 7 only next scan.
REQ-035 reset asserted in CONVERT, adc_done pulsed after release -> all outputs at reset values, no regfile write.
REQ-036 ADC_SCAN_AVG_EN, chan 3 results 100,101,102,105 -> regfile[3]=102, single sample_valid.
